// File: rtl/conv_pkg.sv
// Shared definitions for the convolutional patch engine.
// Contains the scan state encoding, legal patch sizes and the configuration legality check.
package conv_pkg;

  localparam int IMG_DIM_DEFAULT = 28;

  localparam logic [2:0] PATCH_3 = 3'd3;
  localparam logic [2:0] PATCH_5 = 3'd5;
  localparam logic [2:0] PATCH_7 = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_REQ,
    ST_WAIT_PE,
    ST_FINISH,
    ST_ERR
  } scan_state_e;

  // The enable generator applies the same rule, so keep it here.
  function automatic logic cfg_legal(input logic [2:0] patch_size, input logic [2:0] stride);
    logic sizeOk;
    sizeOk = (patch_size == PATCH_3) || (patch_size == PATCH_5) || (patch_size == PATCH_7);
    return sizeOk && (stride != 3'd0) && (stride <= patch_size);
  endfunction

endpackage

// File: rtl/conv_scan_ctrl_if.sv
// Row-fetch and processor-array handshake bundle of the row-scan sequencer.
// master is the sequencer side; slave is the row memory / PE array side.
interface conv_scan_ctrl_if
  import conv_pkg::*;
#(
  parameter int AW = $clog2(IMG_DIM_DEFAULT)
) ();

  logic          row_req_valid;
  logic          row_req_ready;
  logic [AW-1:0] row_addr;
  logic          cycle_detect;
  logic          pe_ack;
  logic          patch_row_strobe;
  logic [AW-1:0] patch_origin_y;

  modport master (
    output row_req_valid,
    output row_addr,
    output cycle_detect,
    output patch_row_strobe,
    output patch_origin_y,
    input  row_req_ready,
    input  pe_ack
  );

  modport slave (
    input  row_req_valid,
    input  row_addr,
    input  cycle_detect,
    input  patch_row_strobe,
    input  patch_origin_y,
    output row_req_ready,
    output pe_ack
  );

endinterface

// File: rtl/scan_watchdog.sv
// Cycle watchdog for the row-scan sequencer; only built when SCAN_TIMEOUT_EN is defined.
// Counts enabled cycles, restarts on clear and flags expiry on the LIMIT-th enabled cycle.
`ifdef SCAN_TIMEOUT_EN
module scan_watchdog #(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  input  logic clear_i,
  output logic expired_o
);

  localparam int CW = $clog2(LIMIT + 1);
  localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  assign expired_o = en_i && (count_q == LAST);

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (en_i && (count_q != LAST)) begin
      count_d = count_q + ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule
`endif

// File: rtl/conv_scan_ctrl.sv
// Row-scan sequencer: walks image rows for a patch size/stride and hands each row to the PE array.
// Build macro SCAN_TIMEOUT_EN adds a REQ/WAIT_PE watchdog that forces the error state.
module conv_scan_ctrl
  import conv_pkg::*;
#(
  parameter int IMG_DIM = IMG_DIM_DEFAULT,
  parameter int AW      = $clog2(IMG_DIM)
`ifdef SCAN_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 255
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [2:0]       patch_size_i,
  input  logic [2:0]       stride_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  conv_scan_ctrl_if.master scan_if
);

  localparam logic [AW:0]   IMG_LIMIT = IMG_DIM[AW:0];
  localparam logic [AW:0]   EXT_ONE   = {{AW{1'b0}}, 1'b1};
  localparam logic [AW-1:0] ROW_ONE   = {{(AW-1){1'b0}}, 1'b1};

  scan_state_e   state_q, state_d;
  logic [AW-1:0] row_q, row_d;
  logic [AW-1:0] origin_q, origin_d;
  logic [2:0]    psize_q, psize_d;
  logic [2:0]    stride_q, stride_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          first_q, first_d;

  // Patch arithmetic is one bit wider than a row address so origin+size never wraps.
  logic [AW:0] psizeExt, strideExt, endRow, originNext;
  logic        rowIsLast, scanEnds, cdPulse;

  assign psizeExt   = {{(AW-2){1'b0}}, psize_q};
  assign strideExt  = {{(AW-2){1'b0}}, stride_q};
  assign endRow     = {1'b0, origin_q} + psizeExt - EXT_ONE;
  assign rowIsLast  = ({1'b0, row_q} == endRow);
  assign originNext = {1'b0, origin_q} + strideExt;
  assign scanEnds   = (originNext + psizeExt) > IMG_LIMIT;
  assign cdPulse    = (state_q == ST_WAIT_PE) && first_q;

  assign scan_if.row_req_valid    = (state_q == ST_REQ);
  assign scan_if.row_addr         = row_q;
  assign scan_if.cycle_detect     = cdPulse;
  assign scan_if.patch_row_strobe = cdPulse && rowIsLast;
  assign scan_if.patch_origin_y   = origin_q;

  assign busy_o = (state_q == ST_CHECK) || (state_q == ST_REQ) ||
                  (state_q == ST_WAIT_PE) || (state_q == ST_FINISH);
  assign done_o = done_q;
  assign err_o  = err_q;

`ifdef SCAN_TIMEOUT_EN
  logic wdExpired;

  scan_watchdog #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk      (clk),
    .rst      (rst),
    .en_i     ((state_q == ST_REQ) || (state_q == ST_WAIT_PE)),
    .clear_i  (state_d != state_q),
    .expired_o(wdExpired)
  );
`endif

  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    origin_d = origin_q;
    psize_d  = psize_q;
    stride_d = stride_q;
    done_d   = done_q;
    err_d    = err_q;
    first_d  = 1'b0;

    case (state_q)
      ST_IDLE, ST_ERR: begin
        if (start_i) begin
          psize_d  = patch_size_i;
          stride_d = stride_i;
          done_d   = 1'b0;
          err_d    = 1'b0;
          state_d  = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (!cfg_legal(psize_q, stride_q)) begin
          err_d   = 1'b1;
          state_d = ST_ERR;
        end else begin
          row_d    = '0;
          origin_d = '0;
          state_d  = ST_REQ;
        end
      end
      ST_REQ: begin
        if (scan_if.row_req_ready) begin
          first_d = 1'b1;
          state_d = ST_WAIT_PE;
        end
      end
      // An ack in the cycle_detect cycle belongs to the previous row and is dropped.
      ST_WAIT_PE: begin
        if (!first_q && scan_if.pe_ack) begin
          if (rowIsLast && scanEnds) begin
            origin_d = originNext[AW-1:0];
            done_d   = 1'b1;
            state_d  = ST_FINISH;
          end else begin
            if (rowIsLast) begin
              origin_d = originNext[AW-1:0];
            end
            row_d   = row_q + ROW_ONE;
            state_d = ST_REQ;
          end
        end
      end
      ST_FINISH: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

`ifdef SCAN_TIMEOUT_EN
    if (wdExpired) begin
      state_d = ST_ERR;
      err_d   = 1'b1;
      done_d  = done_q;
      first_d = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      row_q    <= '0;
      origin_q <= '0;
      psize_q  <= '0;
      stride_q <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      first_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      row_q    <= row_d;
      origin_q <= origin_d;
      psize_q  <= psize_d;
      stride_q <= stride_d;
      done_q   <= done_d;
      err_q    <= err_d;
      first_q  <= first_d;
    end
  end

endmodule

// File: tb/tb_conv_scan_ctrl.sv
// Directed self-checking bench for conv_scan_ctrl; define SCAN_TIMEOUT_EN to also exercise the watchdog.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_conv_scan_ctrl;

  logic       clk;
  logic       rst;
  logic       start;
  logic [2:0] patchSize;
  logic [2:0] stride;
  logic       busy;
  logic       done;
  logic       err;

  int checkCount;
  int failCount;

  conv_scan_ctrl_if #(.AW(5)) scanIf ();

  conv_scan_ctrl #(
    .IMG_DIM(28)
`ifdef SCAN_TIMEOUT_EN
    ,
    .TIMEOUT_CYCLES(16)
`endif
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start),
    .patch_size_i(patchSize),
    .stride_i    (stride),
    .busy_o      (busy),
    .done_o      (done),
    .err_o       (err),
    .scan_if     (scanIf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Results of the most recent applyStimulus run; cycle numbers count from the start cycle.
  int   rowLog[$];
  int   strobeRows[$];
  int   strobeOrigins[$];
  int   cdCount, firstValidCyc, doneCyc, stallHeld, holdViolations;
  logic busyC1, errC1, doneC1, busyAtDone, busyAfter, doneAfter;

  task automatic applyStimulus(input logic [2:0] p, input logic [2:0] s, input int stallRow,
                               input int stallLen, input int ackRow, input int ackLen);
    int cyc, stallLeft, ackHold;
    rowLog.delete(); strobeRows.delete(); strobeOrigins.delete();
    cdCount = 0; firstValidCyc = -1; doneCyc = -1; stallHeld = 0; holdViolations = 0;
    busyAtDone = 1'b0; stallLeft = stallLen; ackHold = 0;
    scanIf.row_req_ready = 1'b0; scanIf.pe_ack = 1'b0;
    @(negedge clk); start = 1'b1; patchSize = p; stride = s;
    @(negedge clk); start = 1'b0; patchSize = 3'd0; stride = 3'd0;
    cyc = 1; busyC1 = busy; errC1 = err; doneC1 = done;
    while (cyc < 2000) begin
      if (done) begin doneCyc = cyc; busyAtDone = busy; break; end
      if (ackHold > 0 && scanIf.row_req_valid) holdViolations++;
      if (scanIf.cycle_detect) begin
        cdCount++;
        if (scanIf.patch_row_strobe) begin
          strobeRows.push_back(int'(scanIf.row_addr));
          strobeOrigins.push_back(int'(scanIf.patch_origin_y));
        end
        if (int'(scanIf.row_addr) == ackRow) ackHold = ackLen;
      end
      if (scanIf.row_req_valid) begin
        if (firstValidCyc < 0) firstValidCyc = cyc;
        if (int'(scanIf.row_addr) == stallRow) stallHeld++;
        if (int'(scanIf.row_addr) == stallRow && stallLeft > 0) begin
          scanIf.row_req_ready = 1'b0; stallLeft--;
        end else begin
          scanIf.row_req_ready = 1'b1; rowLog.push_back(int'(scanIf.row_addr));
        end
      end else begin
        scanIf.row_req_ready = 1'b0;
      end
      if (ackHold > 0) begin scanIf.pe_ack = 1'b0; ackHold--; end
      else scanIf.pe_ack = 1'b1;
      @(negedge clk); cyc++;
    end
    scanIf.row_req_ready = 1'b0; scanIf.pe_ack = 1'b0;
    @(negedge clk); busyAfter = busy; doneAfter = done;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b1; patchSize = 3'd3; stride = 3'd1;
    repeat (3) @(negedge clk);
    checkCount++; if (scanIf.row_req_valid !== 1'b0) begin failCount++; $display("[TB] FAIL reset_valid got=%b want=0", scanIf.row_req_valid); end
    checkCount++; if (scanIf.row_addr !== 5'd0) begin failCount++; $display("[TB] FAIL reset_row_addr got=%0d want=0", scanIf.row_addr); end
    checkCount++; if (scanIf.cycle_detect !== 1'b0) begin failCount++; $display("[TB] FAIL reset_cycle_detect got=%b want=0", scanIf.cycle_detect); end
    checkCount++; if (scanIf.patch_row_strobe !== 1'b0) begin failCount++; $display("[TB] FAIL reset_strobe got=%b want=0", scanIf.patch_row_strobe); end
    checkCount++; if (scanIf.patch_origin_y !== 5'd0) begin failCount++; $display("[TB] FAIL reset_origin got=%0d want=0", scanIf.patch_origin_y); end
    checkCount++; if (busy !== 1'b0) begin failCount++; $display("[TB] FAIL reset_busy_with_start got=%b want=0", busy); end
    checkCount++; if (done !== 1'b0) begin failCount++; $display("[TB] FAIL reset_done got=%b want=0", done); end
    checkCount++; if (err !== 1'b0) begin failCount++; $display("[TB] FAIL reset_err got=%b want=0", err); end
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    checkCount++; if (busy !== 1'b0) begin failCount++; $display("[TB] FAIL reset_release_busy got=%b want=0", busy); end
  endtask

  task automatic test_p3_s1;
    int bad;
    applyStimulus(3'd3, 3'd1, -1, 0, -1, 0);
    checkCount++; if (busyC1 !== 1'b1) begin failCount++; $display("[TB] FAIL p3s1_busy_t1 got=%b want=1", busyC1); end
    checkCount++; if (doneC1 !== 1'b0) begin failCount++; $display("[TB] FAIL p3s1_done_t1 got=%b want=0", doneC1); end
    checkCount++; if (firstValidCyc !== 2) begin failCount++; $display("[TB] FAIL p3s1_first_valid got=%0d want=2", firstValidCyc); end
    bad = 0;
    foreach (rowLog[i]) if (rowLog[i] != i) bad++;
    checkCount++; if (rowLog.size() !== 28 || bad !== 0) begin failCount++; $display("[TB] FAIL p3s1_rows got=%0d rows (%0d misplaced) want=28 in order", rowLog.size(), bad); end
    checkCount++; if (cdCount !== 28) begin failCount++; $display("[TB] FAIL p3s1_cycle_detect got=%0d want=28", cdCount); end
    checkCount++; if (strobeRows.size() !== 26) begin failCount++; $display("[TB] FAIL p3s1_strobe_count got=%0d want=26", strobeRows.size()); end
    bad = 0;
    foreach (strobeRows[i]) if (strobeRows[i] != i + 2 || strobeOrigins[i] != i) bad++;
    checkCount++; if (strobeRows.size() == 0 || strobeRows[0] !== 2 || bad !== 0) begin failCount++; $display("[TB] FAIL p3s1_strobe_rows got=%0d bad entries want first on row 2", bad); end
    checkCount++; if (doneCyc !== 86) begin failCount++; $display("[TB] FAIL p3s1_done_cycle got=%0d want=86", doneCyc); end
    checkCount++; if (busyAtDone !== 1'b1) begin failCount++; $display("[TB] FAIL p3s1_busy_in_finish got=%b want=1", busyAtDone); end
    checkCount++; if (busyAfter !== 1'b0 || doneAfter !== 1'b1) begin failCount++; $display("[TB] FAIL p3s1_after_finish got busy=%b done=%b want busy=0 done=1", busyAfter, doneAfter); end
  endtask

  task automatic test_p5_s3;
    int bad;
    applyStimulus(3'd5, 3'd3, -1, 0, -1, 0);
    checkCount++; if (doneC1 !== 1'b0) begin failCount++; $display("[TB] FAIL p5s3_done_cleared got=%b want=0", doneC1); end
    bad = 0;
    foreach (rowLog[i]) if (rowLog[i] != i) bad++;
    checkCount++; if (rowLog.size() !== 26 || bad !== 0) begin failCount++; $display("[TB] FAIL p5s3_rows got=%0d rows (%0d misplaced) want=26 (0..25)", rowLog.size(), bad); end
    bad = 0;
    foreach (strobeRows[i]) if (strobeOrigins[i] != 3 * i || strobeRows[i] != 3 * i + 4) bad++;
    checkCount++; if (strobeRows.size() !== 8 || bad !== 0) begin failCount++; $display("[TB] FAIL p5s3_origins got=%0d strobes (%0d wrong) want=8", strobeRows.size(), bad); end
    checkCount++; if (doneCyc !== 80) begin failCount++; $display("[TB] FAIL p5s3_done_cycle got=%0d want=80", doneCyc); end
  endtask

  task automatic test_p7_s7;
    int bad;
    applyStimulus(3'd7, 3'd7, -1, 0, -1, 0);
    bad = 0;
    foreach (strobeRows[i]) if (strobeOrigins[i] != 7 * i || strobeRows[i] != 7 * i + 6) bad++;
    checkCount++; if (strobeRows.size() !== 4 || bad !== 0) begin failCount++; $display("[TB] FAIL p7s7_strobes got=%0d strobes (%0d wrong) want rows 6,13,20,27", strobeRows.size(), bad); end
    checkCount++; if (cdCount !== 28) begin failCount++; $display("[TB] FAIL p7s7_cycle_detect got=%0d want=28", cdCount); end
    checkCount++; if (doneCyc !== 86) begin failCount++; $display("[TB] FAIL p7s7_done_cycle got=%0d want=86", doneCyc); end
  endtask

  task automatic test_illegal_config;
    logic [2:0] pTab[3];
    logic [2:0] sTab[3];
    int validSeen;
    pTab[0] = 3'd4; sTab[0] = 3'd1;
    pTab[1] = 3'd3; sTab[1] = 3'd0;
    pTab[2] = 3'd5; sTab[2] = 3'd6;
    scanIf.row_req_ready = 1'b1; scanIf.pe_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      validSeen = 0;
      @(negedge clk); start = 1'b1; patchSize = pTab[i]; stride = sTab[i];
      @(negedge clk); start = 1'b0;
      if (scanIf.row_req_valid) validSeen++;
      checkCount++; if (err !== 1'b0) begin failCount++; $display("[TB] FAIL illegal%0d_err_t1 got=%b want=0", i, err); end
      @(negedge clk);
      checkCount++; if (err !== 1'b1 || busy !== 1'b0) begin failCount++; $display("[TB] FAIL illegal%0d_err_t2 got err=%b busy=%b want err=1 busy=0", i, err, busy); end
      repeat (6) begin
        if (scanIf.row_req_valid) validSeen++;
        @(negedge clk);
      end
      checkCount++; if (validSeen !== 0 || err !== 1'b1) begin failCount++; $display("[TB] FAIL illegal%0d_no_request got valid_cycles=%0d err=%b want 0 and err=1", i, validSeen, err); end
    end
    applyStimulus(3'd3, 3'd3, -1, 0, -1, 0);
    checkCount++; if (errC1 !== 1'b0) begin failCount++; $display("[TB] FAIL recover_err_cleared got=%b want=0", errC1); end
    checkCount++; if (strobeRows.size() !== 9 || rowLog.size() !== 27) begin failCount++; $display("[TB] FAIL recover_scan got strobes=%0d rows=%0d want 9 and 27", strobeRows.size(), rowLog.size()); end
    checkCount++; if (doneCyc !== 83 || err !== 1'b0) begin failCount++; $display("[TB] FAIL recover_done got cycle=%0d err=%b want 83 and err=0", doneCyc, err); end
  endtask

  task automatic test_backpressure;
    int bad;
    applyStimulus(3'd3, 3'd1, 10, 5, 15, 20);
    checkCount++; if (stallHeld !== 6) begin failCount++; $display("[TB] FAIL bp_row10_held got=%0d valid cycles want=6", stallHeld); end
    bad = 0;
    foreach (rowLog[i]) if (rowLog[i] != i) bad++;
    checkCount++; if (rowLog.size() !== 28 || bad !== 0 || cdCount !== 28) begin failCount++; $display("[TB] FAIL bp_single_accept got rows=%0d bad=%0d pulses=%0d want 28/0/28", rowLog.size(), bad, cdCount); end
    checkCount++; if (holdViolations !== 0) begin failCount++; $display("[TB] FAIL bp_no_req_during_ack_wait got=%0d want=0", holdViolations); end
    checkCount++; if (doneCyc !== 110) begin failCount++; $display("[TB] FAIL bp_done_cycle got=%0d want=110", doneCyc); end
  endtask

  task automatic test_rst_midscan;
    logic found;
    int cdAfter;
    found = 1'b0; cdAfter = 0;
    scanIf.row_req_ready = 1'b1; scanIf.pe_ack = 1'b1;
    @(negedge clk); start = 1'b1; patchSize = 3'd3; stride = 3'd1;
    @(negedge clk); start = 1'b0;
    for (int c = 0; c < 200 && !found; c++) begin
      if (scanIf.cycle_detect && scanIf.row_addr == 5'd12) found = 1'b1;
      else @(negedge clk);
    end
    checkCount++; if (found !== 1'b1) begin failCount++; $display("[TB] FAIL rst_reach_row12 got=%b want=1", found); end
    checkCount++; if (scanIf.patch_row_strobe !== 1'b1 || scanIf.patch_origin_y !== 5'd10) begin failCount++; $display("[TB] FAIL rst_row12_strobe got strobe=%b origin=%0d want 1 and 10", scanIf.patch_row_strobe, scanIf.patch_origin_y); end
    rst = 1'b1; scanIf.pe_ack = 1'b0;
    @(negedge clk);
    checkCount++;
    if ({scanIf.row_req_valid, scanIf.row_addr, scanIf.cycle_detect, scanIf.patch_row_strobe,
         scanIf.patch_origin_y, busy, done, err} !== 17'd0) begin
      failCount++;
      $display("[TB] FAIL rst_outputs_zero got valid=%b addr=%0d cd=%b strobe=%b origin=%0d busy=%b done=%b err=%b want all 0",
               scanIf.row_req_valid, scanIf.row_addr, scanIf.cycle_detect, scanIf.patch_row_strobe,
               scanIf.patch_origin_y, busy, done, err);
    end
    rst = 1'b0; scanIf.pe_ack = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (scanIf.cycle_detect) cdAfter++;
    end
    checkCount++; if (cdAfter !== 0 || busy !== 1'b0) begin failCount++; $display("[TB] FAIL rst_quiet got pulses=%0d busy=%b want 0 and 0", cdAfter, busy); end
    scanIf.row_req_ready = 1'b0; scanIf.pe_ack = 1'b0;
  endtask

`ifdef SCAN_TIMEOUT_EN
  task automatic test_timeout;
    logic errAt18, errAt19, validAt19;
    scanIf.row_req_ready = 1'b1; scanIf.pe_ack = 1'b0;
    @(negedge clk); start = 1'b1; patchSize = 3'd3; stride = 3'd1;
    @(negedge clk); start = 1'b0;
    repeat (17) @(negedge clk);
    errAt18 = err;
    @(negedge clk);
    errAt19 = err; validAt19 = scanIf.row_req_valid;
    checkCount++; if (errAt18 !== 1'b0) begin failCount++; $display("[TB] FAIL timeout_early got=%b want=0", errAt18); end
    checkCount++; if (errAt19 !== 1'b1 || validAt19 !== 1'b0 || busy !== 1'b0) begin failCount++; $display("[TB] FAIL timeout_err got err=%b valid=%b busy=%b want 1/0/0", errAt19, validAt19, busy); end
    scanIf.row_req_ready = 1'b0;
  endtask
`endif

  initial begin
    checkCount = 0; failCount = 0;
    rst = 1'b1; start = 1'b0; patchSize = 3'd0; stride = 3'd0;
    scanIf.row_req_ready = 1'b0; scanIf.pe_ack = 1'b0;
    test_reset();
    test_p3_s1();
    test_p5_s3();
    test_p7_s7();
    test_illegal_config();
    test_backpressure();
    test_rst_midscan();
`ifdef SCAN_TIMEOUT_EN
    test_timeout();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
